// File: rtl/sync_fwft_fifo_wrapper.sv
// sync_fwft_fifo_wrapper: single-clock first-word-fall-through FIFO.
// A small prefetch ring hides the 1..3 cycle RAM read latency.
module sync_fwft_fifo_wrapper #(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 128,
  parameter int RAM_PIPE_STAGE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_trans_clr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   prog_full_assert_cfg,
  input  logic [ADDR_WIDTH:0]   prog_full_negate_cfg,
  input  logic [ADDR_WIDTH:0]   prog_empty_assert_cfg,
  input  logic [ADDR_WIDTH:0]   prog_empty_negate_cfg,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic                  ovf_int,
  output logic                  udf_int,
  output logic [ADDR_WIDTH:0]   data_count
);

  localparam int FIFO_DEEP = 1 << ADDR_WIDTH;
  localparam int PF_DEPTH  = RAM_PIPE_STAGE + 1;
  localparam int CW        = ADDR_WIDTH + 1;
  localparam int PAW       = (PF_DEPTH > 2) ? 2 : 1;
  localparam int PFW       = 3;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEEP];
  logic [DATA_WIDTH-1:0] rd_pipe [RAM_PIPE_STAGE];
  logic [DATA_WIDTH-1:0] pf_mem [PF_DEPTH];

  logic [ADDR_WIDTH-1:0]     waddr;
  logic [ADDR_WIDTH-1:0]     raddr;
  logic [CW-1:0]             ram_cnt;
  logic [CW-1:0]             ram_cnt_nxt;
  logic [CW-1:0]             cnt_nxt;
  logic [RAM_PIPE_STAGE-1:0] vld;
  logic [PAW-1:0]            pf_wptr;
  logic [PAW-1:0]            pf_rptr;
  logic [PFW-1:0]            pf_cnt;
  logic [PFW-1:0]            pf_cnt_nxt;
  logic [3:0]                occ;
  logic                      wen;
  logic                      ren;
  logic                      pop;
  logic                      ret;
  logic                      pf_nxt;
  logic                      pe_nxt;

  function automatic logic [PAW-1:0] pf_inc(input logic [PAW-1:0] p);
    return (p == PAW'(PF_DEPTH - 1)) ? '0 : p + PAW'(1);
  endfunction

  assign ret     = vld[RAM_PIPE_STAGE-1];
  assign rd_data = pf_mem[pf_rptr];
  assign empty   = ~rd_valid;

  // handshakes, read credit and next-state counts
  always_comb begin
    wen = wr_en & ~full;
    pop = rd_en & rd_valid;
    // a pop this cycle frees a ring slot, keeping the stream gap-free
    occ = 4'(pf_cnt) + 4'($countones(vld)) - 4'(pop);
    ren = (ram_cnt != '0) & (occ < 4'(PF_DEPTH));
    ram_cnt_nxt = ram_cnt + CW'(wen) - CW'(ren);
    pf_cnt_nxt  = pf_cnt + PFW'(ret) - PFW'(pop);
    cnt_nxt     = data_count + CW'(wen) - CW'(pop);
    pf_nxt = prog_full;
    if (cnt_nxt >= prog_full_assert_cfg)
      pf_nxt = 1'b1;
    else if (cnt_nxt < prog_full_negate_cfg)
      pf_nxt = 1'b0;
    pe_nxt = prog_empty;
    if (cnt_nxt <= prog_empty_assert_cfg)
      pe_nxt = 1'b1;
    else if (cnt_nxt > prog_empty_negate_cfg)
      pe_nxt = 1'b0;
  end

  // RAM write port and fixed-latency read data pipe
  always_ff @(posedge clk) begin
    if (wen)
      mem[waddr] <= wr_data;
    if (ren)
      rd_pipe[0] <= mem[raddr];
    for (int i = 1; i < RAM_PIPE_STAGE; i++)
      rd_pipe[i] <= rd_pipe[i-1];
  end

  // in-flight read valids; a flush drops returning data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (data_trans_clr) begin
      vld <= '0;
    end else begin
      vld[0] <= ren;
      for (int i = 1; i < RAM_PIPE_STAGE; i++)
        vld[i] <= vld[i-1];
    end
  end

  // RAM and prefetch pointers and occupancy counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr   <= '0;
      raddr   <= '0;
      ram_cnt <= '0;
      pf_wptr <= '0;
      pf_rptr <= '0;
      pf_cnt  <= '0;
    end else if (data_trans_clr) begin
      waddr   <= '0;
      raddr   <= '0;
      ram_cnt <= '0;
      pf_wptr <= '0;
      pf_rptr <= '0;
      pf_cnt  <= '0;
    end else begin
      if (wen)
        waddr <= waddr + 1'b1;
      if (ren)
        raddr <= raddr + 1'b1;
      if (ret)
        pf_wptr <= pf_inc(pf_wptr);
      if (pop)
        pf_rptr <= pf_inc(pf_rptr);
      ram_cnt <= ram_cnt_nxt;
      pf_cnt  <= pf_cnt_nxt;
    end
  end

  // prefetch ring storage; head feeds rd_data directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PF_DEPTH; i++)
        pf_mem[i] <= '0;
    end else if (ret && !data_trans_clr) begin
      pf_mem[pf_wptr] <= rd_pipe[RAM_PIPE_STAGE-1];
    end
  end

  // registered status flags, count and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid   <= 1'b0;
      full       <= 1'b0;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
      ovf_int    <= 1'b0;
      udf_int    <= 1'b0;
      data_count <= '0;
    end else if (data_trans_clr) begin
      rd_valid   <= 1'b0;
      full       <= 1'b0;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
      ovf_int    <= 1'b0;
      udf_int    <= 1'b0;
      data_count <= '0;
    end else begin
      rd_valid   <= (pf_cnt_nxt != '0);
      full       <= (ram_cnt_nxt == CW'(FIFO_DEEP));
      prog_full  <= pf_nxt;
      prog_empty <= pe_nxt;
      ovf_int    <= wr_en & full;
      udf_int    <= rd_en & ~rd_valid;
      data_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sync_fwft_fifo_wrapper.sv
// tb_sync_fwft_fifo_wrapper: randomized bench with a queue-based
// reference model plus directed literal checks.
module tb_sync_fwft_fifo_wrapper;

  localparam int AW   = 11;
  localparam int DW   = 128;
  localparam int RPS  = 2;
  localparam int PFD  = RPS + 1;
  localparam int DEEP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          rd_en;
  logic [AW:0]   pfa;
  logic [AW:0]   pfn;
  logic [AW:0]   pea;
  logic [AW:0]   pen;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic          prog_full;
  logic          prog_empty;
  logic          ovf_int;
  logic          udf_int;
  logic [AW:0]   data_count;

  sync_fwft_fifo_wrapper #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RAM_PIPE_STAGE(RPS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_trans_clr(clr),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .prog_full_assert_cfg(pfa),
    .prog_full_negate_cfg(pfn),
    .prog_empty_assert_cfg(pea),
    .prog_empty_negate_cfg(pen),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .empty(empty),
    .full(full),
    .prog_full(prog_full),
    .prog_empty(prog_empty),
    .ovf_int(ovf_int),
    .udf_int(udf_int),
    .data_count(data_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: words in RAM, words issued (with the cycle they become visible)
  logic [DW-1:0] ram_q[$];
  logic [DW-1:0] fl_d[$];
  int            fl_t[$];
  int            cyc;
  logic          m_valid;
  logic          m_full;
  logic          m_pf;
  logic          m_pe;
  logic          m_ovf;
  logic          m_udf;
  int            m_cnt;

  task automatic chkb(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chkc(input string nm, input logic [AW:0] a,
                      input logic [AW:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, a, e, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] a,
                      input logic [DW-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_reset();
    ram_q.delete();
    fl_d.delete();
    fl_t.delete();
    m_valid = 1'b0;
    m_full  = 1'b0;
    m_pf    = 1'b0;
    m_pe    = 1'b1;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    logic wen;
    logic pop;
    if (!rst_n) return;
    cyc++;
    if (clr) begin
      model_reset();
      return;
    end
    wen   = wr_en & ~m_full;
    pop   = rd_en & m_valid;
    m_ovf = wr_en & m_full;
    m_udf = rd_en & ~m_valid;
    if (pop) begin
      void'(fl_d.pop_front());
      void'(fl_t.pop_front());
    end
    // at most PF_DEPTH words issued and not yet consumed
    if (ram_q.size() > 0 && fl_d.size() < PFD) begin
      fl_d.push_back(ram_q.pop_front());
      fl_t.push_back(cyc + RPS);
    end
    if (wen) ram_q.push_back(wr_data);
    m_valid = (fl_d.size() > 0) && (fl_t[0] <= cyc);
    m_full  = (ram_q.size() == DEEP);
    m_cnt   = ram_q.size() + fl_d.size();
    if (m_cnt >= int'(pfa)) m_pf = 1'b1;
    else if (m_cnt < int'(pfn)) m_pf = 1'b0;
    if (m_cnt <= int'(pea)) m_pe = 1'b1;
    else if (m_cnt > int'(pen)) m_pe = 1'b0;
  endtask

  task automatic compare();
    chkb("rd_valid", rd_valid, m_valid);
    chkb("empty", empty, ~m_valid);
    chkb("full", full, m_full);
    chkb("prog_full", prog_full, m_pf);
    chkb("prog_empty", prog_empty, m_pe);
    chkb("ovf_int", ovf_int, m_ovf);
    chkb("udf_int", udf_int, m_udf);
    chkc("data_count", data_count, (AW+1)'(m_cnt));
    if (m_valid) chkd("rd_data", rd_data, fl_d[0]);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic rnd_word();
    wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic run(input int n, input int pw, input int pr, input int pc);
    for (int i = 0; i < n; i++) begin
      rnd_word();
      wr_en = (int'($urandom_range(0, 99)) < pw);
      rd_en = (int'($urandom_range(0, 99)) < pr);
      clr   = (int'($urandom_range(0, 999)) < pc);
      step();
    end
    clr   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic reset_lits(input string tag);
    chkb({tag, "_rd_valid"}, rd_valid, 1'b0);
    chkb({tag, "_empty"}, empty, 1'b1);
    chkb({tag, "_full"}, full, 1'b0);
    chkb({tag, "_prog_full"}, prog_full, 1'b0);
    chkb({tag, "_prog_empty"}, prog_empty, 1'b1);
    chkb({tag, "_ovf"}, ovf_int, 1'b0);
    chkb({tag, "_udf"}, udf_int, 1'b0);
    chkc({tag, "_count"}, data_count, 12'd0);
    chkd({tag, "_rd_data"}, rd_data, 128'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    clr     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    pfa     = 12'd100;
    pfn     = 12'd90;
    pea     = 12'd4;
    pen     = 12'd8;
    cyc     = 0;
    model_reset();
    @(negedge clk);
    reset_lits("rst");
    rst_n = 1'b1;
    repeat (2) step();

    // single word latency
    wr_data = 128'hA5;
    wr_en   = 1'b1;
    step();
    wr_en = 1'b0;
    chkc("lat_cnt_n1", data_count, 12'd1);
    chkb("lat_rv_n1", rd_valid, 1'b0);
    step();
    chkb("lat_rv_n2", rd_valid, 1'b0);
    step();
    chkb("lat_rv_n3", rd_valid, 1'b0);
    step();
    chkb("lat_rv_n4", rd_valid, 1'b1);
    chkd("lat_data_n4", rd_data, 128'hA5);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chkb("lat_empty_n5", empty, 1'b1);
    chkc("lat_cnt_n5", data_count, 12'd0);

    // underflow pulse
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chkb("udf_pulse", udf_int, 1'b1);
    step();
    chkb("udf_clear", udf_int, 1'b0);
    chkc("udf_cnt", data_count, 12'd0);

    // thresholds: fill to 100, drain to 0 one word per cycle
    for (int i = 1; i <= 100; i++) begin
      rnd_word();
      wr_en = 1'b1;
      step();
      chkb("thr_pf_fill", prog_full, i >= 100);
      chkb("thr_pe_fill", prog_empty, i <= 8);
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 99; i >= 0; i--) begin
      step();
      chkc("thr_cnt_drain", data_count, 12'(i));
      chkb("thr_pf_drain", prog_full, i >= 90);
      chkb("thr_pe_drain", prog_empty, i <= 4);
    end
    rd_en = 1'b0;

    // fill to capacity, overflow, then drain
    for (int i = 1; i <= DEEP + PFD; i++) begin
      rnd_word();
      wr_en = 1'b1;
      step();
      chkb("cap_full", full, i == DEEP + PFD);
    end
    chkc("cap_cnt", data_count, 12'd2051);
    rnd_word();
    step();
    wr_en = 1'b0;
    chkb("ovf_pulse", ovf_int, 1'b1);
    chkc("ovf_cnt", data_count, 12'd2051);
    step();
    chkb("ovf_clear", ovf_int, 1'b0);
    for (int i = 0; i < 8000 && m_cnt > 0; i++) begin
      rd_en = (int'($urandom_range(0, 99)) < 70);
      step();
    end
    rd_en = 1'b0;
    chkc("cap_drained", data_count, 12'd0);

    // continuous push and pop
    wr_en = 1'b1;
    rd_en = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      rnd_word();
      step();
      if (k >= 4) begin
        chkc("stream_cnt", data_count, 12'd4);
        chkb("stream_rv", rd_valid, 1'b1);
      end
    end
    wr_en = 1'b0;
    repeat (6) step();
    rd_en = 1'b0;

    // flush with stored and in-flight words
    wr_en = 1'b1;
    for (int i = 0; i < 503; i++) begin
      rnd_word();
      step();
    end
    rd_en = 1'b1;
    repeat (3) begin
      rnd_word();
      step();
    end
    clr = 1'b1;
    step();
    clr   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chkc("clr_cnt", data_count, 12'd0);
    chkb("clr_empty", empty, 1'b1);
    chkb("clr_pe", prog_empty, 1'b1);
    chkb("clr_pf", prog_full, 1'b0);
    repeat (6) begin
      step();
      chkb("clr_no_stale", rd_valid, 1'b0);
    end

    // asynchronous reset mid-stream
    wr_en = 1'b1;
    rd_en = 1'b1;
    repeat (20) begin
      rnd_word();
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    reset_lits("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    step();

    // randomized segments
    for (int s = 0; s < 30; s++) begin
      pfa = 12'($urandom_range(0, DEEP + PFD));
      pfn = 12'($urandom_range(0, int'(pfa)));
      pea = 12'($urandom_range(0, 200));
      pen = 12'($urandom_range(int'(pea), int'(pea) + 200));
      run(250, int'($urandom_range(10, 95)),
          int'($urandom_range(10, 95)), 3);
    end
    run(2500, 90, 10, 0);
    run(3000, 30, 80, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fwft_fifo_wrapper.md
# sync_fwft_fifo_wrapper

Parametrised single-clock FIFO with first-word-fall-through output. It hides a RAM read latency of 1–3 cycles behind an internal prefetch buffer, so the head word is always presented on `rd_data` with `rd_valid`. Runtime-programmable full/empty thresholds and a total occupancy count are provided. It replaces fixed-latency FIFO wrappers in datapaths that need zero-latency pop and full throughput.

## Interface
- `ADDR_WIDTH`, 11, RAM address width; `FIFO_DEEP = 1<<ADDR_WIDTH` RAM entries
- `DATA_WIDTH`, 128, word width
- `RAM_PIPE_STAGE`, 2, RAM read latency in cycles; legal values 1..3
- `PF_DEPTH`, `RAM_PIPE_STAGE+1`, prefetch buffer depth; derived, not overridable
- `clk`, in, 1, the single clock
- `rst_n`, in, 1, reset: asynchronous, active-low
- `data_trans_clr`, in, 1, synchronous flush of all contents and flags
- `wr_data`, in, DATA_WIDTH, write word
- `wr_en`, in, 1, push request
- `rd_en`, in, 1, pop of the presented head word
- `prog_full_assert_cfg` / `prog_full_negate_cfg`, in, ADDR_WIDTH+1, prog_full thresholds
- `prog_empty_assert_cfg` / `prog_empty_negate_cfg`, in, ADDR_WIDTH+1, prog_empty thresholds
- `rd_data`, out, DATA_WIDTH, head word; valid while `rd_valid`=1
- `rd_valid`, out, 1, head word present
- `empty`, out, 1, equals `!rd_valid`
- `full`, out, 1, RAM occupancy == FIFO_DEEP
- `prog_full` / `prog_empty`, out, 1, threshold flags with hysteresis
- `ovf_int` / `udf_int`, out, 1, one-cycle error pulses
- `data_count`, out, ADDR_WIDTH+1, total words held (RAM + in-flight + prefetch); max FIFO_DEEP+PF_DEPTH

## Operation
- Push: `wen = wr_en & !full`. Write to RAM at `waddr`, which increments modulo FIFO_DEEP. `ram_cnt` increments.
- RAM read issue: `ren = (ram_cnt != 0) & (pf_cnt + inflight_cnt < PF_DEPTH)`. `raddr` increments modulo FIFO_DEEP; `ram_cnt` decrements.
- A RAM_PIPE_STAGE-deep valid shift register tracks in-flight reads. `inflight_cnt` is the popcount of that register.
- Returning RAM data is written into the prefetch ring, which has PF_DEPTH entries and its own wrapping pointers. The credit check guarantees the ring never overflows.
- Pop: `pop = rd_en & rd_valid` advances the prefetch read pointer. `rd_data` always shows the ring head; it is registered-array output with no combinational path from `wr_data`.
- Simultaneous push+issue, issue+return, and return+pop in the same cycle are all legal. Every counter sums its increments and decrements in that cycle.
- `data_count`: next = count + wen − pop.
- `prog_full` is computed on next-count:
  - sets when next ≥ assert_cfg;
  - clears when next < negate_cfg;
  - otherwise holds.
- `prog_empty` is computed on next-count:
  - sets when next ≤ assert_cfg;
  - clears when next > negate_cfg;
  - otherwise holds.
- Config is expected with negate ≤ assert for full and negate ≥ assert for empty. Other config values are not checked; the flag then follows set-priority.
- `full` is registered from next `ram_cnt` == FIFO_DEEP. It deasserts in the cycle after a RAM read issues.
- `ovf_int` ← `wr_en & full`. `udf_int` ← `rd_en & !rd_valid`. Both are registered one-cycle pulses. The rejected push or pop has no other effect.
- `data_trans_clr`:
  - zeroes all pointers, counters, in-flight valids and the prefetch ring state;
  - forces flags to their reset values in the next cycle;
  - overrides any push, pop or return in the same cycle;
  - discards RAM data still returning.

## Timing
- Reset values:
  - `rd_valid`=0, `empty`=1, `full`=0, `prog_full`=0, `prog_empty`=1, `ovf_int`=0, `udf_int`=0;
  - `data_count`=0, `rd_data`=0.
- Write-to-read latency, empty FIFO: push accepted in cycle n → RAM read issued in cycle n+1 → `rd_valid`=1 in cycle n+RAM_PIPE_STAGE+2. With default parameters that is cycle n+4.
- Throughput: with `rd_en` held high and data available, one word per cycle is sustained. The credit loop is RAM_PIPE_STAGE+1 cycles long and PF_DEPTH covers it.
- `data_count`, `full`, `prog_*` and `rd_valid` are all registered and update in the cycle after the causing edge.
- Accepted capacity is FIFO_DEEP + PF_DEPTH words when the reader stalls: the prefetch drains the RAM.
- Asynchronous reset mid-transfer returns all outputs to reset values immediately. In-flight data is lost.

## Test plan
- Reset, then one push of 0xA5 in cycle 10 (defaults) → `rd_valid`=1 and `rd_data`=0xA5 in cycle 14; `data_count`=1 from cycle 11; `rd_en` in cycle 14 → `empty`=1 in cycle 15.
- Push 2048+3 words with no pops → `full`=1 after word 2051 is accepted; `data_count`=2051; extra `wr_en` → `ovf_int` pulse one cycle later; data order is intact on drain.
- Continuous push and pop for 10000 words, with RAM_PIPE_STAGE swept over 1, 2 and 3 → no bubbles after the first word, values in order, `data_count` constant at steady state.
- Thresholds: full assert/negate = 100/90, empty assert/negate = 4/8; fill to 100 → `prog_full` sets; drain to 89 → clears; `prog_empty` clears at 9 and sets at 4.
- `data_trans_clr` pulsed while 3 words are in flight and 500 are stored → next cycle `data_count`=0, `empty`=1, `prog_empty`=1; no stale `rd_valid` appears afterwards.
- `rd_en` on an empty FIFO → `udf_int` one-cycle pulse, no pointer change; `rst_n` asserted mid-stream → all outputs at reset values without waiting for `clk`.
